// File: rtl/acc_instr_sequencer.sv
// Host-side instruction sequencer: instruction FIFO, issue stage, read-latency tracker and response FIFO.
// Optional performance counters are compiled in when ACC_SEQ_PERF_CNT_EN is defined.
module acc_instr_sequencer #(
    parameter int          depth       = 2,
    parameter int          W           = 8,
    parameter int          INS_W       = (depth > 2) ? depth : 2,
    parameter int          INS_D       = ((1 << depth) > W) ? (1 << depth) : W,
    parameter int          INS_WIDTH   = 4 + 2 + 2 * INS_W + INS_D,
    parameter logic [3:0]  READ_OPCODE = 4'b0011,
    parameter int          RD_LAT      = 1,
    parameter int          FIFO_AW     = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [INS_WIDTH-1:0]   in_instr,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [INS_WIDTH-1:0]   instruction,
    input  logic [W-1:0]           dataOut,
    output logic [INS_WIDTH+W-1:0] rsp_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    input  logic                   hold,
    output logic                   idle
`ifdef ACC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]            issue_cnt,
    output logic [31:0]            read_cnt,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int RSP_W = INS_WIDTH + W;
    localparam logic [FIFO_AW:0] PTR_ONE    = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0] CREDIT_MAX = (FIFO_AW + 1)'(DEPTH);

    logic [INS_WIDTH-1:0] ififo_mem [DEPTH];
    logic [RSP_W-1:0]     rfifo_mem [DEPTH];

    logic [FIFO_AW:0] iwr_ptr_q, iwr_ptr_d, ird_ptr_q, ird_ptr_d;
    logic [FIFO_AW:0] rwr_ptr_q, rwr_ptr_d, rrd_ptr_q, rrd_ptr_d;
    logic [FIFO_AW:0] credits_q, credits_d;
    logic             in_ready_q, in_ready_d;
    logic [INS_WIDTH-1:0] instruction_q, instruction_d;

    logic                 stage_vld_q [RD_LAT];
    logic                 stage_vld_d [RD_LAT];
    logic [INS_WIDTH-1:0] stage_ins_q [RD_LAT];
    logic [INS_WIDTH-1:0] stage_ins_d [RD_LAT];

    logic                 ififo_empty, rfifo_empty, ififo_full_next;
    logic [INS_WIDTH-1:0] head;
    logic                 head_is_read, issue, issue_read;
    logic                 host_push, rsp_push, rsp_pop, any_stage_vld;

    always_comb begin
        ififo_empty  = (iwr_ptr_q == ird_ptr_q);
        rfifo_empty  = (rwr_ptr_q == rrd_ptr_q);
        head         = ififo_mem[ird_ptr_q[FIFO_AW-1:0]];
        head_is_read = (head[INS_WIDTH-1 -: 4] == READ_OPCODE);
        // A read only leaves the FIFO when a response slot is reserved for it.
        issue        = !hold && !ififo_empty && (!head_is_read || (credits_q != '0));
        issue_read   = issue && head_is_read;
        host_push    = in_valid && in_ready_q;
        rsp_push     = stage_vld_q[RD_LAT-1];
        rsp_pop      = !rfifo_empty && rsp_ready;

        iwr_ptr_d = host_push ? iwr_ptr_q + PTR_ONE : iwr_ptr_q;
        ird_ptr_d = issue     ? ird_ptr_q + PTR_ONE : ird_ptr_q;
        rwr_ptr_d = rsp_push  ? rwr_ptr_q + PTR_ONE : rwr_ptr_q;
        rrd_ptr_d = rsp_pop   ? rrd_ptr_q + PTR_ONE : rrd_ptr_q;

        ififo_full_next = (iwr_ptr_d[FIFO_AW] != ird_ptr_d[FIFO_AW]) &&
                          (iwr_ptr_d[FIFO_AW-1:0] == ird_ptr_d[FIFO_AW-1:0]);
        in_ready_d      = !ififo_full_next;

        instruction_d = issue ? head : '0;

        case ({issue_read, rsp_pop})
            2'b10:   credits_d = credits_q - PTR_ONE;
            2'b01:   credits_d = credits_q + PTR_ONE;
            default: credits_d = credits_q;
        endcase

        stage_vld_d[0] = issue_read;
        stage_ins_d[0] = instruction_d;
        for (int i = 1; i < RD_LAT; i++) begin
            stage_vld_d[i] = stage_vld_q[i-1];
            stage_ins_d[i] = stage_ins_q[i-1];
        end

        any_stage_vld = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            any_stage_vld = any_stage_vld | stage_vld_q[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            iwr_ptr_q     <= '0;
            ird_ptr_q     <= '0;
            rwr_ptr_q     <= '0;
            rrd_ptr_q     <= '0;
            credits_q     <= CREDIT_MAX;
            in_ready_q    <= 1'b0;
            instruction_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                stage_vld_q[i] <= 1'b0;
                stage_ins_q[i] <= '0;
            end
        end else begin
            iwr_ptr_q     <= iwr_ptr_d;
            ird_ptr_q     <= ird_ptr_d;
            rwr_ptr_q     <= rwr_ptr_d;
            rrd_ptr_q     <= rrd_ptr_d;
            credits_q     <= credits_d;
            in_ready_q    <= in_ready_d;
            instruction_q <= instruction_d;
            for (int i = 0; i < RD_LAT; i++) begin
                stage_vld_q[i] <= stage_vld_d[i];
                stage_ins_q[i] <= stage_ins_d[i];
            end
        end
    end

    // Storage arrays carry no reset so they map onto RAM primitives.
    always_ff @(posedge CLK) begin
        if (host_push) begin
            ififo_mem[iwr_ptr_q[FIFO_AW-1:0]] <= in_instr;
        end
        if (rsp_push) begin
            rfifo_mem[rwr_ptr_q[FIFO_AW-1:0]] <= {stage_ins_q[RD_LAT-1], dataOut};
        end
    end

    assign in_ready    = in_ready_q;
    assign instruction = instruction_q;
    assign rsp_valid   = !rfifo_empty;
    assign rsp_data    = rfifo_empty ? '0 : rfifo_mem[rrd_ptr_q[FIFO_AW-1:0]];
    assign idle        = ififo_empty && rfifo_empty && !any_stage_vld;

`ifdef ACC_SEQ_PERF_CNT_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] read_cnt_q, read_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        issue_cnt_d = (issue && (issue_cnt_q != '1)) ? issue_cnt_q + 32'd1 : issue_cnt_q;
        read_cnt_d  = (issue_read && (read_cnt_q != '1)) ? read_cnt_q + 32'd1 : read_cnt_q;
        stall_cnt_d = (!ififo_empty && !issue && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1
                                                                         : stall_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            issue_cnt_q <= '0;
            read_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            read_cnt_q  <= read_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign read_cnt  = read_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_acc_instr_sequencer.sv
// Directed bench for acc_instr_sequencer: issue-order and response scoreboards checked every cycle.
module tb_acc_instr_sequencer;

    localparam int         DEPTH_P   = 2;
    localparam int         W         = 8;
    localparam int         INS_WIDTH = 18;
    localparam int         RSP_W     = INS_WIDTH + W;
    localparam int         RD_LAT    = 3;
    localparam int         FIFO_AW   = 2;
    localparam logic [3:0] RD_OP     = 4'b0011;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b1;
    logic [INS_WIDTH-1:0]   in_instr = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [INS_WIDTH-1:0]   instruction;
    logic [W-1:0]           dataOut = '0;
    logic [RSP_W-1:0]       rsp_data;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic                   hold = 1'b0;
    logic                   idle;
`ifdef ACC_SEQ_PERF_CNT_EN
    logic [31:0]            issue_cnt, read_cnt, stall_cnt;
`endif

    acc_instr_sequencer #(
        .depth(DEPTH_P), .W(W), .READ_OPCODE(RD_OP), .RD_LAT(RD_LAT), .FIFO_AW(FIFO_AW)
    ) dut (
        .CLK(CLK), .RST(RST), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .dataOut(dataOut), .rsp_data(rsp_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .hold(hold), .idle(idle)
`ifdef ACC_SEQ_PERF_CNT_EN
        , .issue_cnt(issue_cnt), .read_cnt(read_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int a5_cyc = -1;
    int rd_issued = 0;
    int pops = 0;
    logic [INS_WIDTH-1:0] iq [$];
    logic [RSP_W-1:0]     rq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] data_of(input int c);
        if (c == a5_cyc) return 8'hA5;
        return 8'(c * 29 + 17);
    endfunction

    function automatic logic [INS_WIDTH-1:0] mk(input logic [3:0] op, input int k);
        return {op, 14'(k * 37 + 5)};
    endfunction

    // One clock cycle: account handshakes before the edge, monitor issue after it.
    task automatic step();
        logic rst_now;
        logic [INS_WIDTH-1:0] exp_ins;
        rst_now = RST;
        if (!rst_now && in_valid && in_ready) iq.push_back(in_instr);
        if (!rst_now && rsp_valid && rsp_ready) begin
            pops++;
            if (rq.size() == 0) chk("rsp_unexpected", 64'(rsp_data), 64'd0);
            else chk("rsp_data", 64'(rsp_data), 64'(rq.pop_front()));
        end
        @(posedge CLK);
        #1;
        cyc++;
        dataOut = data_of(cyc);
        if (rst_now) begin
            iq.delete();
            rq.delete();
        end
        if (instruction !== '0) begin
            if (iq.size() == 0) chk("issue_unexpected", 64'(instruction), 64'd0);
            else begin
                exp_ins = iq.pop_front();
                chk("issue_order", 64'(instruction), 64'(exp_ins));
                if (exp_ins[INS_WIDTH-1 -: 4] == RD_OP) begin
                    rq.push_back({exp_ins, data_of(cyc + RD_LAT - 1)});
                    rd_issued++;
                end
            end
        end
    endtask

    task automatic push_word(input logic [INS_WIDTH-1:0] w);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_instr = w;
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = in_ready;
            step();
        end
        chk("push_accepted", 64'(acc), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, k, base, stale;
        logic pre;
        logic [INS_WIDTH-1:0] h [5];

        // Reset state
        dataOut = data_of(0);
        step();
        chk("rst_instruction", 64'(instruction), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        RST = 1'b0;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Three non-read words back to back
        push_word(mk(4'b0001, 1));
        chk("min_latency_nop", 64'(instruction), 64'd0);
        push_word(mk(4'b0001, 2));
        chk("seq_w0", 64'(instruction), 64'(mk(4'b0001, 1)));
        push_word(mk(4'b0001, 3));
        chk("seq_w1", 64'(instruction), 64'(mk(4'b0001, 2)));
        in_valid = 1'b0;
        step();
        chk("seq_w2", 64'(instruction), 64'(mk(4'b0001, 3)));
        step();
        chk("seq_nop_after", 64'(instruction), 64'd0);
        chk("seq_no_rsp", 64'(rsp_valid), 64'd0);
        chk("seq_idle", 64'(idle), 64'd1);

        // Single read, dataOut = A5 in its capture cycle
        a5_cyc = cyc + 2 + RD_LAT - 1;
        push_word(mk(RD_OP, 10));
        in_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("rd_latency", 64'(n), 64'(2 + RD_LAT));
        chk("rd_a5_data", 64'(rsp_data), 64'({mk(RD_OP, 10), 8'hA5}));
        repeat (3) step();
        chk("rd_valid_holds", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rd_popped", 64'(rsp_valid), 64'd0);
        step();
        chk("rd_idle", 64'(idle), 64'd1);

        // Hold: FIFO fills after 2^FIFO_AW words, fifth accepted after release
        for (int i = 0; i < 5; i++) h[i] = mk(4'b0001, 20 + i);
        hold = 1'b1;
        k = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_instr = h[k];
            pre = in_ready;
            step();
            if (pre) k++;
        end
        chk("hold_accepted", 64'(k), 64'(1 << FIFO_AW));
        chk("hold_full", 64'(in_ready), 64'd0);
        chk("hold_nop", 64'(instruction), 64'd0);
        hold = 1'b0;
        for (int i = 0; i < 10 && k < 5; i++) begin
            in_instr = h[k];
            pre = in_ready;
            step();
            if (pre) k++;
        end
        in_valid = 1'b0;
        chk("hold_fifth", 64'(k), 64'd5);
        repeat (8) step();
        chk("hold_drained", 64'(iq.size()), 64'd0);

        // Credit limit with rsp_ready low
        base = rd_issued;
        for (int i = 0; i < 6; i++) push_word(mk(RD_OP, 40 + i));
        in_valid = 1'b0;
        repeat (10) step();
        chk("credit_issued4", 64'(rd_issued - base), 64'(1 << FIFO_AW));
        chk("credit_stall_nop", 64'(instruction), 64'd0);
        chk("credit_rsp_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        repeat (6) step();
        chk("credit_release5", 64'(rd_issued - base), 64'd5);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        repeat (6) step();
        chk("credit_release6", 64'(rd_issued - base), 64'd6);
        rsp_ready = 1'b1;
        for (int i = 0; i < 30 && (rsp_valid || rq.size() != 0); i++) step();
        chk("credit_rq_empty", 64'(rq.size()), 64'd0);
        chk("credit_idle", 64'(idle), 64'd1);

        // Interleaved read / non-read / read with consumer always ready
        base = pops;
        push_word(mk(RD_OP, 60));
        push_word(mk(4'b0101, 61));
        push_word(mk(RD_OP, 62));
        in_valid = 1'b0;
        for (int i = 0; i < 30 && (pops - base) < 2; i++) step();
        chk("mix_two_rsp", 64'(pops - base), 64'd2);
        repeat (3) step();
        chk("mix_no_extra", 64'(pops - base), 64'd2);
        rsp_ready = 1'b0;

        // Reset with reads in flight / unread and words queued
        push_word(mk(RD_OP, 70));
        push_word(mk(RD_OP, 71));
        push_word(mk(RD_OP, 72));
        hold = 1'b1;
        push_word(mk(RD_OP, 73));
        push_word(mk(RD_OP, 74));
        in_valid = 1'b0;
        chk("busy_before_rst", 64'(idle), 64'd0);
        RST = 1'b1;
        step();
        chk("midrst_instruction", 64'(instruction), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_idle", 64'(idle), 64'd1);
        RST = 1'b0;
        hold = 1'b0;
        rsp_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            step();
            if (rsp_valid) stale++;
        end
        chk("midrst_no_stale", 64'(stale), 64'd0);
        chk("midrst_final_idle", 64'(idle), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
